// File: rtl/pp_loader_pkg.sv
// Shared geometry helpers for the partial-product column loader and its compressor bench.
// Column i of an NxN multiplier array has height min(i+1, 2N-1-i); columns pack LSB-first.
package pp_loader_pkg;

  localparam int N_DEFAULT = 9;

  function automatic int col_height(input int n, input int i);
    return ((i + 1) < (2 * n - 1 - i)) ? (i + 1) : (2 * n - 1 - i);
  endfunction

  function automatic int col_offset(input int n, input int i);
    int sum;
    sum = 0;
    for (int j = 0; j < i; j++) sum += col_height(n, j);
    return sum;
  endfunction

  localparam int C = 2 * N_DEFAULT - 1;
  localparam int T = N_DEFAULT * N_DEFAULT;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } load_state_t;

endpackage

// File: rtl/pp_column_shifter.sv
// One serial-in column register of configurable depth; new bit enters the LSB.
// Optional PP_LOADER_PARITY_EN adds a running XOR of the held bits.
module pp_column_shifter #(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [DEPTH-1:0] bits
`ifdef PP_LOADER_PARITY_EN
  ,
  output logic             parity
`endif
);

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bits <= '0;
        else if (clear) bits <= '0;
        else if (en)    bits <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bits <= '0;
        else if (clear) bits <= '0;
        else if (en)    bits <= {bits[DEPTH-2:0], din};
      end
    end
  endgenerate

`ifdef PP_LOADER_PARITY_EN
  // Incoming bit joins the XOR, discarded MSB leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     parity <= 1'b0;
    else if (clear) parity <= 1'b0;
    else if (en)    parity <= parity ^ din ^ bits[DEPTH-1];
  end
`endif

endmodule

// File: rtl/pp_column_loader.sv
// Serial loader for the triangular partial-product column array of an NxN multiplier,
// with valid/ready handshake, batch/sliding output modes and optional PP_LOADER_PARITY_EN.
module pp_column_loader
  import pp_loader_pkg::*;
#(
  parameter int N      = 9,
  parameter bit STREAM = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N-2:0]         src_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N-1:0]         col_bits,
  output logic [$clog2(N+1)-1:0] fill_cnt
`ifdef PP_LOADER_PARITY_EN
  ,
  output logic [2*N-2:0]         col_parity
`endif
);

  localparam int COLS = 2 * N - 1;
  localparam int CW   = $clog2(N + 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  load_state_t state_reg;
  logic        shift_en;

  // In sliding mode a shift is only legal when the current window is being consumed.
  assign in_ready = (state_reg == ST_FILL) || (STREAM && out_ready);
  assign shift_en = in_valid && in_ready && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FILL;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state_reg <= ST_FILL;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (shift_en) begin
            fill_cnt <= fill_cnt + CW'(1);
            if (fill_cnt == N_LAST) begin
              state_reg <= ST_FULL;
              out_valid <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (out_ready && !(STREAM && in_valid)) begin
            state_reg <= ST_FILL;
            out_valid <= 1'b0;
            fill_cnt  <= STREAM ? N_LAST : '0;
          end
        end
        default: begin
          state_reg <= ST_FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int H   = col_height(N, gi);
      localparam int OFF = col_offset(N, gi);
      logic [H-1:0] col_q;

      pp_column_shifter #(.DEPTH(H)) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .en     (shift_en),
        .din    (src_in[gi]),
        .bits   (col_q)
`ifdef PP_LOADER_PARITY_EN
        ,
        .parity (col_parity[gi])
`endif
      );

      assign col_bits[OFF +: H] = col_q;
    end
  endgenerate

endmodule

// File: tb/tb_pp_column_loader.sv
// Randomised self-checking bench: three loader instances (N=3 batch, N=3 sliding, N=9 batch)
// compared against a history-based reference model; parity checked when PP_LOADER_PARITY_EN is set.
module tb_pp_column_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_clear = 0, a_in_valid = 0, a_out_ready = 0;
  logic [4:0] a_src = '0;
  logic a_in_ready, a_out_valid;
  logic [8:0] a_col;
  logic [1:0] a_fill;

  logic b_clear = 0, b_in_valid = 0, b_out_ready = 0;
  logic [4:0] b_src = '0;
  logic b_in_ready, b_out_valid;
  logic [8:0] b_col;
  logic [1:0] b_fill;

  logic c_clear = 0, c_in_valid = 0, c_out_ready = 0;
  logic [16:0] c_src = '0;
  logic c_in_ready, c_out_valid;
  logic [80:0] c_col;
  logic [3:0] c_fill;

`ifdef PP_LOADER_PARITY_EN
  logic [4:0]  a_par, b_par;
  logic [16:0] c_par;
`endif

  pp_column_loader #(.N(3), .STREAM(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .src_in(a_src), .out_valid(a_out_valid), .out_ready(a_out_ready), .col_bits(a_col),
    .fill_cnt(a_fill)
`ifdef PP_LOADER_PARITY_EN
    , .col_parity(a_par)
`endif
  );

  pp_column_loader #(.N(3), .STREAM(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .src_in(b_src), .out_valid(b_out_valid), .out_ready(b_out_ready), .col_bits(b_col),
    .fill_cnt(b_fill)
`ifdef PP_LOADER_PARITY_EN
    , .col_parity(b_par)
`endif
  );

  pp_column_loader #(.N(9), .STREAM(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .src_in(c_src), .out_valid(c_out_valid), .out_ready(c_out_ready), .col_bits(c_col),
    .fill_cnt(c_fill)
`ifdef PP_LOADER_PARITY_EN
    , .col_parity(c_par)
`endif
  );

  // Reference model: the last nine accepted input vectors (hist[0] newest) plus fill/full.
  typedef struct packed {
    logic [8:0][16:0] hist;
    logic [3:0]       fill;
    logic             full;
  } model_t;

  model_t ma, mb, mc;
  int tests_run = 0;
  int tests_failed = 0;

  function automatic model_t model_next(model_t m, int n, bit stream, logic clr, logic v,
                                        logic r, logic [16:0] s);
    model_t x;
    logic rdy;
    x = m;
    rdy = !m.full || (stream && r);
    if (clr) begin
      x = '0;
    end else begin
      if (v && rdy) x.hist = {m.hist[7:0], s};
      if (!m.full) begin
        if (v) begin
          x.fill = 4'(m.fill + 1);
          if (int'(m.fill) + 1 == n) x.full = 1'b1;
        end
      end else if (r) begin
        if (!(stream && v)) begin
          x.full = 1'b0;
          x.fill = stream ? 4'(n - 1) : 4'd0;
        end
      end
    end
    return x;
  endfunction

  // Column i, bit j is input bit i from the j-th most recent accepted shift.
  function automatic logic [80:0] model_cols(model_t m, int n);
    logic [80:0] c;
    int off, h;
    c = '0;
    off = 0;
    for (int i = 0; i < 2 * n - 1; i++) begin
      h = (i + 1 < 2 * n - 1 - i) ? i + 1 : 2 * n - 1 - i;
      for (int j = 0; j < h; j++) c[off + j] = m.hist[j][i];
      off += h;
    end
    return c;
  endfunction

  function automatic logic [16:0] model_par(model_t m, int n);
    logic [16:0] p;
    int h;
    p = '0;
    for (int i = 0; i < 2 * n - 1; i++) begin
      h = (i + 1 < 2 * n - 1 - i) ? i + 1 : 2 * n - 1 - i;
      for (int j = 0; j < h; j++) p[i] = p[i] ^ m.hist[j][i];
    end
    return p;
  endfunction

  task automatic cyc_a(input logic clr, input logic v, input logic [4:0] s, input logic r);
    a_clear = clr; a_in_valid = v; a_src = s; a_out_ready = r;
    @(posedge clk);
    ma = model_next(ma, 3, 1'b0, clr, v, r, 17'(s));
    #1;
    $display("[TB] A clr=%b v=%b src=%b ordy=%b -> ovld=%b fill=%0d col=%h",
             clr, v, s, r, a_out_valid, a_fill, a_col);
  endtask

  task automatic cyc_b(input logic clr, input logic v, input logic [4:0] s, input logic r);
    b_clear = clr; b_in_valid = v; b_src = s; b_out_ready = r;
    @(posedge clk);
    mb = model_next(mb, 3, 1'b1, clr, v, r, 17'(s));
    #1;
    $display("[TB] B clr=%b v=%b src=%b ordy=%b -> ovld=%b fill=%0d col=%h",
             clr, v, s, r, b_out_valid, b_fill, b_col);
  endtask

  task automatic cyc_c(input logic clr, input logic v, input logic [16:0] s, input logic r);
    c_clear = clr; c_in_valid = v; c_src = s; c_out_ready = r;
    @(posedge clk);
    mc = model_next(mc, 9, 1'b0, clr, v, r, s);
    #1;
    $display("[TB] C clr=%b v=%b src=%h ordy=%b -> ovld=%b fill=%0d col=%h",
             clr, v, s, r, c_out_valid, c_fill, c_col);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ma = '0; mb = '0; mc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    tests_run++;
    if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    tests_run++;
    if (a_col !== 9'h0 || a_fill !== 2'd0) begin tests_failed++; $display("FAIL reset_state got col=%h fill=%0d exp 0/0", a_col, a_fill); end
    tests_run++;
    if (c_col !== 81'h0 || b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_bc got c_col=%h b_vld=%b exp 0", c_col, b_out_valid); end
  endtask

  task automatic test_batch_fill();
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 1'b1, 5'h1F, 1'b0);
      tests_run++;
      if (a_fill !== 2'(k + 1) || a_out_valid !== (k == 2)) begin
        tests_failed++;
        $display("FAIL batch_fill_step%0d got fill=%0d vld=%b exp fill=%0d vld=%b", k, a_fill, a_out_valid, k + 1, k == 2);
      end
    end
    tests_run++;
    if (a_col !== 9'h1FF || a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL batch_full got col=%h rdy=%b exp 1ff/0", a_col, a_in_ready); end
    for (int k = 0; k < 4; k++) begin
      cyc_a(1'b0, 1'b1, 5'($urandom), 1'b0);
      tests_run++;
      if (a_col !== 9'h1FF || a_fill !== 2'd3 || a_out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL batch_stall%0d got col=%h fill=%0d vld=%b exp 1ff/3/1", k, a_col, a_fill, a_out_valid);
      end
    end
  endtask

  task automatic test_pattern();
    logic [80:0] exp;
    cyc_a(1'b0, 1'b0, 5'h0, 1'b1);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_fill !== 2'd0 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pattern_consume got vld=%b fill=%0d rdy=%b exp 0/0/1", a_out_valid, a_fill, a_in_ready);
    end
    cyc_a(1'b0, 1'b1, 5'b10101, 1'b0);
    cyc_a(1'b0, 1'b1, 5'b01010, 1'b0);
    cyc_a(1'b0, 1'b1, 5'b10101, 1'b0);
    tests_run++;
    if (a_col[5:3] !== 3'b101 || a_col[2:1] !== 2'b10 || a_col[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pattern_fields got c2=%b c1=%b c0=%b exp 101/10/1", a_col[5:3], a_col[2:1], a_col[0]);
    end
    exp = model_cols(ma, 3);
    tests_run++;
    if (a_col !== exp[8:0]) begin tests_failed++; $display("FAIL pattern_model got %h exp %h", a_col, exp[8:0]); end
    cyc_a(1'b0, 1'b0, 5'h0, 1'b1);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_fill !== 2'd0 || a_col !== exp[8:0]) begin
      tests_failed++;
      $display("FAIL pattern_after_consume got vld=%b fill=%0d col=%h exp 0/0/%h", a_out_valid, a_fill, a_col, exp[8:0]);
    end
  endtask

  task automatic test_random_n9();
    logic [80:0] exp;
    logic [8:0] col8;
    for (int k = 0; k < 60; k++) begin
      cyc_c(1'b0, $urandom_range(0, 3) != 0, 17'($urandom), $urandom_range(0, 2) == 0);
      exp = model_cols(mc, 9);
      tests_run++;
      if (c_col !== exp || c_out_valid !== mc.full || c_fill !== mc.fill) begin
        tests_failed++;
        $display("FAIL n9_cycle%0d got vld=%b fill=%0d col=%h exp vld=%b fill=%0d col=%h",
                 k, c_out_valid, c_fill, c_col, mc.full, mc.fill, exp);
      end
      if (mc.full) begin
        for (int j = 0; j < 9; j++) col8[j] = mc.hist[j][8];
        tests_run++;
        if (c_col[44:36] !== col8) begin tests_failed++; $display("FAIL n9_col8 got %b exp %b", c_col[44:36], col8); end
      end
`ifdef PP_LOADER_PARITY_EN
      tests_run++;
      if (c_par !== model_par(mc, 9)) begin tests_failed++; $display("FAIL n9_parity got %h exp %h", c_par, model_par(mc, 9)); end
`endif
    end
  endtask

  task automatic test_stream();
    logic [80:0] exp;
    for (int k = 0; k < 3; k++) cyc_b(1'b0, 1'b1, 5'($urandom), 1'b0);
    tests_run++;
    if (b_out_valid !== 1'b1 || b_fill !== 2'd3) begin tests_failed++; $display("FAIL stream_first got vld=%b fill=%0d exp 1/3", b_out_valid, b_fill); end
    for (int k = 0; k < 20; k++) begin
      cyc_b(1'b0, 1'b1, 5'($urandom), 1'b1);
      exp = model_cols(mb, 3);
      tests_run++;
      if (b_out_valid !== 1'b1 || b_fill !== 2'd3 || b_col !== exp[8:0]) begin
        tests_failed++;
        $display("FAIL stream_win%0d got vld=%b fill=%0d col=%h exp 1/3/%h", k, b_out_valid, b_fill, b_col, exp[8:0]);
      end
`ifdef PP_LOADER_PARITY_EN
      tests_run++;
      if (b_par !== model_par(mb, 3)[4:0]) begin tests_failed++; $display("FAIL stream_parity got %b exp %b", b_par, model_par(mb, 3)); end
`endif
    end
    cyc_b(1'b0, 1'b0, 5'h0, 1'b1);
    tests_run++;
    if (b_out_valid !== 1'b0 || b_fill !== 2'd2 || b_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_drop got vld=%b fill=%0d rdy=%b exp 0/2/1", b_out_valid, b_fill, b_in_ready);
    end
    cyc_b(1'b0, 1'b1, 5'($urandom), 1'b0);
    exp = model_cols(mb, 3);
    tests_run++;
    if (b_out_valid !== 1'b1 || b_fill !== 2'd3 || b_col !== exp[8:0]) begin
      tests_failed++;
      $display("FAIL stream_refill got vld=%b fill=%0d col=%h exp 1/3/%h", b_out_valid, b_fill, b_col, exp[8:0]);
    end
    cyc_b(1'b0, 1'b1, 5'($urandom), 1'b0);
    tests_run++;
    if (b_col !== exp[8:0] || b_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_stall got col=%h rdy=%b exp %h/0", b_col, b_in_ready, exp[8:0]);
    end
  endtask

  task automatic test_reset_mid();
    cyc_a(1'b0, 1'b1, 5'($urandom), 1'b0);
    cyc_a(1'b0, 1'b1, 5'($urandom) | 5'h1, 1'b0);
    tests_run++;
    if (a_fill !== 2'd2) begin tests_failed++; $display("FAIL midreset_pre got fill=%0d exp 2", a_fill); end
    rst_n = 1'b0;
    ma = '0; mb = '0; mc = '0;
    #2;
    tests_run++;
    if (a_fill !== 2'd0 || a_col !== 9'h0 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async got fill=%0d col=%h vld=%b exp 0/0/0", a_fill, a_col, a_out_valid);
    end
    tests_run++;
    if (b_col !== 9'h0 || b_out_valid !== 1'b0 || c_fill !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_bc got b_col=%h b_vld=%b c_fill=%0d exp 0", b_col, b_out_valid, c_fill);
    end
    #2 rst_n = 1'b1;
    cyc_a(1'b0, 1'b0, 5'h0, 1'b0);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_fill !== 2'd0) begin
      tests_failed++;
      $display("FAIL midreset_after got vld=%b rdy=%b fill=%0d exp 0/1/0", a_out_valid, a_in_ready, a_fill);
    end
  endtask

  task automatic test_clear();
    cyc_a(1'b0, 1'b1, 5'h1F, 1'b0);
    cyc_a(1'b0, 1'b1, 5'h1F, 1'b0);
    cyc_a(1'b1, 1'b1, 5'h1F, 1'b0);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_fill !== 2'd0 || a_col !== 9'h0 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_with_shift got vld=%b fill=%0d col=%h rdy=%b exp 0/0/0/1", a_out_valid, a_fill, a_col, a_in_ready);
    end
    cyc_a(1'b0, 1'b0, 5'h0, 1'b0);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_fill !== 2'd0) begin tests_failed++; $display("FAIL clear_no_glitch got vld=%b fill=%0d exp 0/0", a_out_valid, a_fill); end
    for (int k = 0; k < 3; k++) cyc_a(1'b0, 1'b1, 5'($urandom), 1'b0);
    cyc_a(1'b1, 1'b0, 5'h0, 1'b1);
    tests_run++;
    if (a_out_valid !== 1'b0 || a_col !== 9'h0 || a_fill !== ma.fill[1:0]) begin
      tests_failed++;
      $display("FAIL clear_full got vld=%b col=%h fill=%0d exp 0/0/0", a_out_valid, a_col, a_fill);
    end
`ifdef PP_LOADER_PARITY_EN
    tests_run++;
    if (a_par !== 5'h0) begin tests_failed++; $display("FAIL clear_parity got %b exp 0", a_par); end
`endif
  endtask

  initial begin
    test_reset();
    test_batch_fill();
    test_pattern();
    test_random_n9();
    test_stream();
    test_reset_mid();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
